// File: rtl/lisnoc_packetizer_pkg.sv
// Shared flit definitions for the LISNoC packetizer: flit type encodings,
// packetizer FSM states and the clog2 helper used to size length fields.
package lisnoc_packetizer_pkg;

    localparam int FLIT_TYPE_WIDTH = 2;

    typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_LAST    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } pkt_state_e;

    // Bits needed to represent values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        if (result == 0) result = 1;
        return result;
    endfunction

endpackage

// File: rtl/lisnoc_packetizer_outreg.sv
// Two-entry skid buffer on the flit port: fully registered outputs, one flit per
// cycle, upstream is throttled only by the registered skid-full flag.
module lisnoc_packetizer_outreg #(
    parameter int flit_width = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [flit_width-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [flit_width-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [flit_width-1:0] main_reg;
    logic [flit_width-1:0] skid_reg;
    logic                  main_valid_reg;
    logic                  skid_valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!main_valid_reg || out_ready) begin
            // Output slot frees up: drain the skid first, input is blocked meanwhile.
            if (skid_valid_reg) begin
                main_reg       <= skid_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= in_valid;
                if (in_valid) main_reg <= in_flit;
            end
        end else if (in_valid && !skid_valid_reg) begin
            skid_reg       <= in_flit;
            skid_valid_reg <= 1'b1;
        end
    end

    assign in_ready  = !skid_valid_reg;
    assign out_flit  = main_reg;
    assign out_valid = main_valid_reg;

endmodule

// File: rtl/lisnoc_packetizer.sv
// Source-side packet assembler: header + payload stream -> typed flits.
// Define LISNOC_PACKETIZER_OUTREG_EN to register the flit port through a skid buffer.
module lisnoc_packetizer
    import lisnoc_packetizer_pkg::*;
#(
    parameter  int data_width  = 32,
    parameter  int max_payload = 15,
    localparam int flit_width  = data_width + FLIT_TYPE_WIDTH,
    localparam int len_width   = clog2(max_payload + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] req_header,
    input  logic [len_width-1:0]  req_len,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [data_width-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [flit_width-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  len_err
);

    localparam logic [len_width-1:0] MAX_LEN = len_width'(max_payload);
    localparam logic [len_width-1:0] ONE     = len_width'(1);

    pkt_state_e            state_reg, state_next;
    logic [data_width-1:0] header_reg, header_next;
    logic [len_width-1:0]  remaining_reg, remaining_next;
    logic                  len_err_reg, len_err_next;

    flit_type_e            ftype;
    logic [flit_width-1:0] fsm_flit;
    logic                  fsm_valid;
    logic                  fsm_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            header_reg    <= '0;
            remaining_reg <= '0;
            len_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            header_reg    <= header_next;
            remaining_reg <= remaining_next;
            len_err_reg   <= len_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        header_next    = header_reg;
        remaining_next = remaining_reg;
        len_err_next   = 1'b0;
        ftype          = FLIT_PAYLOAD;
        fsm_flit       = '0;
        fsm_valid      = 1'b0;
        req_ready      = 1'b0;
        data_ready     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    header_next = req_header;
                    state_next  = ST_HEADER;
                    // Oversized requests are truncated so the packet still fits the buffer.
                    if (req_len > MAX_LEN) begin
                        remaining_next = MAX_LEN;
                        len_err_next   = 1'b1;
                    end else begin
                        remaining_next = req_len;
                    end
                end
            end
            ST_HEADER: begin
                ftype     = (remaining_reg == '0) ? FLIT_SINGLE : FLIT_HEADER;
                fsm_flit  = {ftype, header_reg};
                fsm_valid = 1'b1;
                if (fsm_ready) begin
                    state_next = (remaining_reg == '0) ? ST_IDLE : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // Payload words pass straight through; handshake is shared end to end.
                ftype      = (remaining_reg == ONE) ? FLIT_LAST : FLIT_PAYLOAD;
                fsm_flit   = {ftype, data_in};
                fsm_valid  = data_valid;
                data_ready = fsm_ready;
                if (data_valid && fsm_ready) begin
                    remaining_next = remaining_reg - ONE;
                    if (remaining_reg == ONE) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign len_err = len_err_reg;

`ifdef LISNOC_PACKETIZER_OUTREG_EN
    lisnoc_packetizer_outreg #(
        .flit_width(flit_width)
    ) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (fsm_flit),
        .in_valid (fsm_valid),
        .in_ready (fsm_ready),
        .out_flit (out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );
`else
    assign out_flit  = fsm_flit;
    assign out_valid = fsm_valid;
    assign fsm_ready = out_ready;
`endif

endmodule
